demux4_deser: RTL and testbench
===============================

DEMUX4_DESER -- requirements
Module: demux4_deser

Interface
REQ-001 SHALL have parameter: WIDTH, 1, bit width of one lane/beat.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: in_data  input  WIDTH  serial beat, one lane's worth.
REQ-005 SHALL have port: in_valid  input  1  in_data valid this cycle.
REQ-006 SHALL have port: in_sync  input  1  beat marks lane 0 (frame start); qualified by accept.
REQ-007 SHALL have port: in_ready  output  1  block accepts beat this cycle.
REQ-008 SHALL have port: out_word  output  [3:0][WIDTH]  assembled frame; lane i = beat taken at slot i.
REQ-009 SHALL have port: out_valid  output  1  out_word holds an undelivered frame.
REQ-010 SHALL have port: out_ready  input  1  consumer takes out_word this cycle.
REQ-011 SHALL have port: slot  output  2  current lane select (0..3), registered.
REQ-012 SHALL have port: err  output  1  sticky; frame misalignment detected.

Function
REQ-013 SHALL accept a beat only when in_valid && in_ready (accept).
REQ-014 SHALL, on accept, write in_data into assembly lane[slot] and advance slot 0->1->2->3->0; slot SHALL hold on cycles without accept.
REQ-015 SHALL drive in_ready = (slot != 3) || !out_valid || out_ready (combinational); only the frame-completing beat stalls.
REQ-016 SHALL, on accept at slot 3, load the full assembly (lanes 0-2 plus this beat in lane 3) into out_word and set out_valid on the next rising edge; latency one cycle after the 4th beat.
REQ-017 SHALL clear out_valid when out_valid && out_ready and no new frame completes that cycle.
REQ-018 SHALL, on simultaneous drain and frame completion, keep out_valid = 1 and load the new frame; no bubble.
REQ-019 SHALL hold out_word stable while out_valid && !out_ready.
REQ-020 SHALL, on accept with in_sync = 1 and slot != 0, discard the partial frame, write the beat to lane 0, set slot = 1, and set err = 1.
REQ-021 SHALL treat in_sync = 1 at slot 0 as normal; in_sync without accept SHALL be ignored.
REQ-022 SHALL keep err set until reset; no other clear path.
REQ-023 SHALL ignore in_data, in_sync when no accept occurs.

Reset
REQ-024 SHALL, while reset = 1 (asynchronously, mid-frame or not), force slot = 0, out_valid = 0, out_word = 0, err = 0, assembly lanes = 0.
REQ-025 SHALL discard any partial frame on reset; first accepted beat after reset release lands in lane 0.
REQ-026 SHALL drive in_ready = 1 during and immediately after reset.

Structure
REQ-027 SHALL place in package demux4_pkg: LANES = 4, typedef enum slot_t {SLOT0, SLOT1, SLOT2, SLOT3} used as the state register.
REQ-028 SHALL instantiate one sub-module demux1_4: combinational 2-to-4 one-hot lane write-enable decoder from slot and accept, built from two levels of 1-to-2 demux stages.
REQ-029 SHALL keep all sequential logic in demux4_deser; demux1_4 contains no state.

Verification (WIDTH = 1)
REQ-030 SHALL cover: beats 1,0,1,1 on consecutive cycles, in_sync on first, out_ready = 1 -> out_word = 4'b1101 (lane3..lane0), out_valid high one cycle after 4th beat, slot 0,1,2,3,0.
REQ-031 SHALL cover: out_ready = 0, frame A full, frame B beats 0-2 accepted -> in_ready = 0 at slot 3, out_word = frame A unchanged; raise out_ready -> frame B loaded next cycle.
REQ-032 SHALL cover: out_valid = 1, out_ready = 1, 4th beat accepted same cycle -> out_valid stays 1, out_word updates next edge.
REQ-033 SHALL cover: beats 1,1 then in_sync beat 0 at slot 2 -> err = 1, slot = 1, lane 0 = 0; following beats 1,1,1 -> out_word = 4'b1110.
REQ-034 SHALL cover: reset asserted between edges at slot 2 with out_valid = 1 -> slot, out_valid, out_word, err = 0 immediately, before next edge; next beat lands in lane 0.
REQ-035 SHALL cover: in_valid gaps of 1-3 idle cycles between beats -> slot holds, frame result identical to REQ-030.

Source files
------------

// File: rtl/demux4_pkg.sv
// Shared definitions for the 4-lane deserialiser: lane count, slot encoding
// and slot sequencing helper.
package demux4_pkg;

    localparam int LANES = 4;

    typedef enum logic [1:0] {
        SLOT0 = 2'd0,
        SLOT1 = 2'd1,
        SLOT2 = 2'd2,
        SLOT3 = 2'd3
    } slot_t;

    function automatic slot_t next_slot(input slot_t s);
        slot_t n;
        case (s)
            SLOT0:   n = SLOT1;
            SLOT1:   n = SLOT2;
            SLOT2:   n = SLOT3;
            SLOT3:   n = SLOT0;
            default: n = SLOT0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/demux1_4.sv
// Stateless one-hot lane write-enable decoder: enable routed by sel[1]
// through a first 1-to-2 stage, then by sel[0] through a second stage.
module demux1_4
    import demux4_pkg::*;
(
    input  logic [1:0]       i_sel,
    input  logic             i_en,
    output logic [LANES-1:0] o_we
);

    logic [1:0] w_half;

    assign w_half[0] = i_en & ~i_sel[1];
    assign w_half[1] = i_en &  i_sel[1];

    assign o_we[0] = w_half[0] & ~i_sel[0];
    assign o_we[1] = w_half[0] &  i_sel[0];
    assign o_we[2] = w_half[1] & ~i_sel[0];
    assign o_we[3] = w_half[1] &  i_sel[0];

endmodule

// File: rtl/demux4_deser.sv
// Serial-to-parallel deserialiser: four accepted beats form one output frame,
// with sync-based realignment and single-entry output holding register.
module demux4_deser
    import demux4_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [WIDTH-1:0]            in_data,
    input  logic                        in_valid,
    input  logic                        in_sync,
    output logic                        in_ready,
    output logic [LANES-1:0][WIDTH-1:0] out_word,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [1:0]                  slot,
    output logic                        err
);

    slot_t                        r_slot;
    logic [LANES-1:0][WIDTH-1:0]  r_lane;
    logic [LANES-1:0][WIDTH-1:0]  r_out_word;
    logic                         r_out_valid;
    logic                         r_err;

    logic                         w_accept;
    logic                         w_resync;
    logic                         w_complete;
    logic [1:0]                   w_wr_sel;
    logic [LANES-1:0]             w_we;

    // Only the frame-completing beat can stall, and only behind an undrained frame.
    assign in_ready   = (r_slot != SLOT3) || !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_resync   = w_accept && in_sync && (r_slot != SLOT0);
    assign w_complete = w_accept && !w_resync && (r_slot == SLOT3);

    // Lane select for the write decoder; a resync beat always lands in lane 0.
    always_comb begin
        w_wr_sel = 2'd0;
        if (w_resync) begin
            w_wr_sel = 2'd0;
        end else begin
            w_wr_sel = r_slot;
        end
    end

    demux1_4 u_lane_dec (
        .i_sel (w_wr_sel),
        .i_en  (w_accept),
        .o_we  (w_we)
    );

    // Assembly lanes; a resync drops the partial frame before storing the beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lane <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (w_we[i]) begin
                    r_lane[i] <= in_data;
                end else if (w_resync) begin
                    r_lane[i] <= '0;
                end
            end
        end
    end

    // Slot sequencing: advance per accepted beat, restart after lane 0 on resync.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot <= SLOT0;
        end else if (w_resync) begin
            r_slot <= SLOT1;
        end else if (w_accept) begin
            r_slot <= next_slot(r_slot);
        end
    end

    // Output frame register; a completing frame wins over a same-cycle drain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_word  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_complete) begin
            r_out_word  <= {in_data, r_lane[2], r_lane[1], r_lane[0]};
            r_out_valid <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Sticky misalignment flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_resync) begin
            r_err <= 1'b1;
        end
    end

    assign out_word  = r_out_word;
    assign out_valid = r_out_valid;
    assign slot      = r_slot;
    assign err       = r_err;

endmodule

// File: tb/tb_demux4_deser.sv
// Directed bench for demux4_deser (WIDTH = 1): a queue-based frame model is
// compared every cycle, plus literal expectations at the key scenario points.
module tb_demux4_deser;

    logic             clk;
    logic             reset;
    logic [0:0]       in_data;
    logic             in_valid;
    logic             in_sync;
    logic             in_ready;
    logic [3:0][0:0]  out_word;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       slot;
    logic             err;

    int n_vec  = 0;
    int n_fail = 0;

    // Frame model: beats collected so far, delivered frame, flags.
    logic       mdl_part[$];
    logic [3:0] mdl_out;
    logic       mdl_ov;
    logic       mdl_err;

    demux4_deser #(.WIDTH(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_sync   (in_sync),
        .in_ready  (in_ready),
        .out_word  (out_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .slot      (slot),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic mdl_ready();
        return (mdl_part.size() != 3) || !mdl_ov || out_ready;
    endfunction

    task automatic mdl_clear();
        mdl_part.delete();
        mdl_out = 4'd0;
        mdl_ov  = 1'b0;
        mdl_err = 1'b0;
    endtask

    // Model step for one rising edge, using the inputs held across that edge.
    task automatic mdl_step();
        logic acc;
        logic done;
        acc  = in_valid && mdl_ready();
        done = 1'b0;
        if (acc) begin
            if (in_sync && mdl_part.size() != 0) begin
                mdl_part.delete();
                mdl_part.push_back(in_data[0]);
                mdl_err = 1'b1;
            end else if (mdl_part.size() == 3) begin
                mdl_out = {in_data[0], mdl_part[2], mdl_part[1], mdl_part[0]};
                mdl_ov  = 1'b1;
                done    = 1'b1;
                mdl_part.delete();
            end else begin
                mdl_part.push_back(in_data[0]);
            end
        end
        if (!done && mdl_ov && out_ready) mdl_ov = 1'b0;
    endtask

    // Compare process: advance the model on each rising edge, check on the falling edge.
    initial begin
        mdl_clear();
        forever begin
            @(posedge clk);
            if (!reset) mdl_step();
            @(negedge clk);
            if (reset) mdl_clear();
            chk("slot",      {30'd0, slot},      mdl_part.size());
            chk("out_valid", {31'd0, out_valid}, {31'd0, mdl_ov});
            chk("out_word",  {28'd0, out_word},  {28'd0, mdl_out});
            chk("err",       {31'd0, err},       {31'd0, mdl_err});
            chk("in_ready",  {31'd0, in_ready},  {31'd0, mdl_ready()});
        end
    end

    // Hold inputs for one rising edge; returns 1 time unit after that edge.
    task automatic drive(input logic v, input logic d, input logic s, input logic r);
        in_valid  = v;
        in_data   = d;
        in_sync   = s;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [3:0] b, input logic r);
        for (int i = 0; i < 4; i++) drive(1'b1, b[i], (i == 0), r);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = 1'b0; in_sync = 1'b0; out_ready = 1'b0;
        #2;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_slot", {30'd0, slot}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Basic frame 1,0,1,1 with slot walk.
        drive(1'b1, 1'b1, 1'b1, 1'b1); chk("r030_slot1", {30'd0, slot}, 32'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b1); chk("r030_slot2", {30'd0, slot}, 32'd2);
        drive(1'b1, 1'b1, 1'b0, 1'b1); chk("r030_slot3", {30'd0, slot}, 32'd3);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        chk("r030_slot0", {30'd0, slot}, 32'd0);
        chk("r030_valid", {31'd0, out_valid}, 32'd1);
        chk("r030_word", {28'd0, out_word}, 32'hD);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("r030_drained", {31'd0, out_valid}, 32'd0);

        // Backpressure: frame A held, frame B stalls at slot 3.
        frame(4'b0110, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1; in_data = 1'b1; #1;
        chk("r031_stall", {31'd0, in_ready}, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        chk("r031_hold", {28'd0, out_word}, 32'h6);
        chk("r031_slot", {30'd0, slot}, 32'd3);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        chk("r031_frame_b", {28'd0, out_word}, 32'h9);
        chk("r031_valid", {31'd0, out_valid}, 32'd1);

        // Drain and completion in the same cycle: no bubble.
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        chk("r032_valid", {31'd0, out_valid}, 32'd1);
        chk("r032_word", {28'd0, out_word}, 32'hE);
        drive(1'b0, 1'b0, 1'b0, 1'b1);

        // Misaligned sync at slot 2.
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        chk("r033_err", {31'd0, err}, 32'd1);
        chk("r033_slot", {30'd0, slot}, 32'd1);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        chk("r033_word", {28'd0, out_word}, 32'hE);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        chk("r033_sticky", {31'd0, err}, 32'd1);

        // Asynchronous reset between edges at slot 2 with a frame pending.
        frame(4'b1010, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("r034_slot", {30'd0, slot}, 32'd0);
        chk("r034_valid", {31'd0, out_valid}, 32'd0);
        chk("r034_word", {28'd0, out_word}, 32'd0);
        chk("r034_err", {31'd0, err}, 32'd0);
        chk("r034_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        chk("r034_lane0", {28'd0, out_word}, 32'h1);

        // Idle gaps between beats.
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        chk("r035_hold1", {30'd0, slot}, 32'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) drive(1'b0, 1'b1, 1'b1, 1'b1);
        chk("r035_hold2", {30'd0, slot}, 32'd2);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("r035_hold3", {30'd0, slot}, 32'd3);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        chk("r035_word", {28'd0, out_word}, 32'hD);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
